// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default
// starvation limit and the word-index slice used by the 256-word DataMemory.
package data_mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int DEF_STARVE_LIMIT = 8;
  localparam int WORD_IDX_HI      = 9;
  localparam int WORD_IDX_LO      = 2;

  function automatic logic [7:0] word_index(input logic [31:0] addr);
    return addr[WORD_IDX_HI:WORD_IDX_LO];
  endfunction

endpackage

// File: rtl/data_mem_arbiter_burst_addr_gen.sv
// Burst address generator: captures base/len on load, advances one word per
// step and flags the final beat.
module data_mem_arbiter_burst_addr_gen #(
  parameter int LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [31:0]      base_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [31:0]      beat_addr_o,
  output logic             last_beat_o
);

  logic [31:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]      beat_off;

  // Byte offset of the current beat; the add wraps modulo 2^32 and keeps base[1:0].
  assign beat_off    = {{(30 - LEN_W){1'b0}}, beat_cnt_q, 2'b00};
  assign beat_addr_o = base_q + beat_off;
  assign last_beat_o = (beat_cnt_q == len_q);

  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    if (load_i) begin
      base_d     = base_i;
      len_d      = len_i;
      beat_cnt_d = '0;
    end else if (step_i && !last_beat_o) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port DataMemory between the CPU load/store path (priority)
// and a burst DMA port whose wait is bounded by a starvation counter.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int LEN_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [31:0]      dma_addr,
  input  logic [LEN_W-1:0] dma_len,
  output logic             dma_ack,
  input  logic [31:0]      dma_wdata,
  output logic             dma_beat,
  output logic [31:0]      dma_rdata,
  output logic             dma_done,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             dbg_state_o
);

  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  // Handshake: dma_ack pulses for one cycle when the burst is granted and the
  // request fields are captured then; afterwards one beat per cycle with no
  // backpressure, and dma_done pulses the cycle after the last beat.

  state_e          state_q, state_d;
  logic [SC_W-1:0] starve_q, starve_d;
  logic            done_q, done_d;
  logic            we_l_q, we_l_d;
  logic            grant_dma;
  logic            load, step, last_beat;
  logic [31:0]     beat_addr;

  data_mem_arbiter_burst_addr_gen #(
    .LEN_W(LEN_W)
  ) u_burst_addr_gen (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (load),
    .step_i     (step),
    .base_i     (dma_addr),
    .len_i      (dma_len),
    .beat_addr_o(beat_addr),
    .last_beat_o(last_beat)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    done_d      = 1'b0;
    we_l_d      = we_l_q;
    grant_dma   = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    cpu_rdata   = '0;
    cpu_stall   = 1'b0;
    dma_ack     = 1'b0;
    dma_beat    = 1'b0;
    dma_rdata   = '0;
    dma_done    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    dbg_state_o = 1'b0;
    // Every output is held at zero while reset is high.
    if (!reset) begin
      dma_done    = done_q;
      dbg_state_o = state_q;
      case (state_q)
        ST_IDLE: begin
          grant_dma = dma_req && (!cpu_req || starve_q == SC_W'(STARVE_LIMIT));
          if (!dma_req || grant_dma) begin
            starve_d = '0;
          end else if (cpu_req && starve_q != SC_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
          end
          if (grant_dma) begin
            dma_ack   = 1'b1;
            load      = 1'b1;
            we_l_d    = dma_we;
            state_d   = ST_BURST;
            cpu_stall = cpu_req;
          end else if (cpu_req) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = !cpu_we;
            mem_write = cpu_we;
            cpu_rdata = cpu_we ? 32'd0 : mem_rdata;
          end
        end
        ST_BURST: begin
          step      = 1'b1;
          dma_beat  = 1'b1;
          mem_addr  = beat_addr;
          mem_write = we_l_q;
          mem_read  = !we_l_q;
          mem_wdata = dma_wdata;
          dma_rdata = mem_rdata;
          cpu_stall = cpu_req;
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      done_q   <= 1'b0;
      we_l_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      done_q   <= done_d;
      we_l_q   <= we_l_d;
    end
  end

endmodule
